// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage RV32I core: decode-stage operand forwarding,
// the load-use stall, the wrong-path flush after a control transfer, and a stall counter.
module hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned WB_FWD = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_load,
  input  logic              id_redirect,
  output logic              stall_if,
  output logic              bubble_ex,
  output logic              flush_if,
  output logic              issue,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]        state, state_nxt;
  logic              ex_v, ex_we, ex_ld, mem_v, mem_we, mem_ld, wb_v, wb_we;
  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  logic load_use;

  assign ex_hit_a  = ex_v  & ex_we  & (ex_rd  != '0) & (ex_rd  == id_rs1) & id_use_rs1;
  assign ex_hit_b  = ex_v  & ex_we  & (ex_rd  != '0) & (ex_rd  == id_rs2) & id_use_rs2;
  assign mem_hit_a = mem_v & mem_we & (mem_rd != '0) & (mem_rd == id_rs1) & id_use_rs1;
  assign mem_hit_b = mem_v & mem_we & (mem_rd != '0) & (mem_rd == id_rs2) & id_use_rs2;
  assign wb_hit_a  = wb_v  & wb_we  & (wb_rd  != '0) & (wb_rd  == id_rs1) & id_use_rs1;
  assign wb_hit_b  = wb_v  & wb_we  & (wb_rd  != '0) & (wb_rd  == id_rs2) & id_use_rs2;

  assign load_use = id_valid & ex_ld & (ex_hit_a | ex_hit_b);

  // A load in EX never forwards; its value first becomes available from MEM.
  function automatic logic [1:0] pick(input logic ex_hit, input logic ex_is_ld,
                                      input logic mem_hit, input logic wb_hit);
    if (ex_hit && !ex_is_ld)           return 2'b01;
    else if (mem_hit)                  return 2'b10;
    else if (wb_hit && (WB_FWD != 0))  return 2'b11;
    else                               return 2'b00;
  endfunction

  always_comb begin
    stall_if  = 1'b0;
    flush_if  = 1'b0;
    issue     = 1'b0;
    state_nxt = ST_RUN;
    case (state)
      ST_FLUSH: state_nxt = ST_RUN;
      default: begin
        if (load_use) begin
          stall_if  = 1'b1;
          state_nxt = ST_STALL;
        end else begin
          issue = id_valid;
          if (id_valid && id_redirect) begin
            flush_if  = 1'b1;
            state_nxt = ST_FLUSH;
          end
        end
      end
    endcase
    bubble_ex = ~issue;
  end

  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    if (id_valid && (state != ST_FLUSH)) begin
      fwd_a = pick(ex_hit_a, ex_ld, mem_hit_a, wb_hit_a);
      fwd_b = pick(ex_hit_b, ex_ld, mem_hit_b, wb_hit_b);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      stall_count <= '0;
      ex_v  <= 1'b0; ex_rd  <= '0; ex_we  <= 1'b0; ex_ld  <= 1'b0;
      mem_v <= 1'b0; mem_rd <= '0; mem_we <= 1'b0; mem_ld <= 1'b0;
      wb_v  <= 1'b0; wb_rd  <= '0; wb_we  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (stall_if && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
      wb_v  <= mem_v; wb_rd  <= mem_rd; wb_we  <= mem_we;
      mem_v <= ex_v;  mem_rd <= ex_rd;  mem_we <= ex_we;  mem_ld <= ex_ld;
      ex_v  <= issue; ex_rd  <= id_rd;  ex_we  <= id_reg_write; ex_ld <= id_load;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding distances, load-use, redirect flush,
// x0 handling, priority, async reset and counter saturation (second instance, CNT_W=2, WB_FWD=0).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_load, id_redirect;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic        stall_if, bubble_ex, flush_if, issue;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_count;

  logic        stall_if2, bubble_ex2, flush_if2, issue2;
  logic [1:0]  fwd_a2, fwd_b2;
  logic [1:0]  stall_count2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .WB_FWD(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_load(id_load), .id_redirect(id_redirect),
    .stall_if(stall_if), .bubble_ex(bubble_ex), .flush_if(flush_if), .issue(issue),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
  );

  hazard_ctrl #(.REG_AW(5), .WB_FWD(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_load(id_load), .id_redirect(id_redirect),
    .stall_if(stall_if2), .bubble_ex(bubble_ex2), .flush_if(flush_if2), .issue(issue2),
    .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_count(stall_count2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input int v, input int r1, input int r2, input int u1, input int u2,
                     input int rd, input int we, input int ld, input int rdr);
    id_valid     = 1'(v);
    id_rs1       = 5'(r1);
    id_rs2       = 5'(r2);
    id_use_rs1   = 1'(u1);
    id_use_rs2   = 1'(u2);
    id_rd        = 5'(rd);
    id_reg_write = 1'(we);
    id_load      = 1'(ld);
    id_redirect  = 1'(rdr);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) adv();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drv(1, 1, 2, 1, 1, 5, 1, 0, 0);
    @(negedge clk);
    chk("rst_stall_if", 32'(stall_if), 32'd0);
    chk("rst_flush_if", 32'(flush_if), 32'd0);
    chk("rst_issue", 32'(issue), 32'd1);
    chk("rst_bubble", 32'(bubble_ex), 32'd0);
    chk("rst_fwd_a", 32'(fwd_a), 32'd0);
    chk("rst_count", 32'(stall_count), 32'd0);
    adv();
    rst = 1'b0;
    drain();

    // add x5; add x6,x5,x1
    drv(1, 1, 2, 1, 1, 5, 1, 0, 0); adv();
    drv(1, 5, 1, 1, 1, 6, 1, 0, 0); @(negedge clk);
    chk("b2b_fwd_a", 32'(fwd_a), 32'd1);
    chk("b2b_fwd_b", 32'(fwd_b), 32'd0);
    chk("b2b_stall", 32'(stall_if), 32'd0);
    adv(); drain();

    drv(1, 1, 2, 1, 1, 5, 1, 0, 0); adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); adv();
    drv(1, 5, 1, 1, 1, 6, 1, 0, 0); @(negedge clk);
    chk("nop1_fwd_a", 32'(fwd_a), 32'd2);
    adv(); drain();

    drv(1, 1, 2, 1, 1, 5, 1, 0, 0); adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); adv(); adv();
    drv(1, 5, 1, 1, 1, 6, 1, 0, 0); @(negedge clk);
    chk("nop2_fwd_a", 32'(fwd_a), 32'd3);
    chk("nop2_nowb_fwd_a", 32'(fwd_a2), 32'd0);
    adv(); drain();

    // lw x7; add x8,x7,x7
    drv(1, 1, 0, 1, 0, 7, 1, 1, 0); adv();
    drv(1, 7, 7, 1, 1, 8, 1, 0, 0); @(negedge clk);
    chk("lu_stall_if", 32'(stall_if), 32'd1);
    chk("lu_bubble", 32'(bubble_ex), 32'd1);
    chk("lu_issue", 32'(issue), 32'd0);
    adv(); @(negedge clk);
    chk("lu2_fwd_a", 32'(fwd_a), 32'd2);
    chk("lu2_fwd_b", 32'(fwd_b), 32'd2);
    chk("lu2_issue", 32'(issue), 32'd1);
    chk("lu2_stall_if", 32'(stall_if), 32'd0);
    chk("lu2_count", 32'(stall_count), 32'd1);
    adv(); drain();

    // taken beq
    drv(1, 1, 2, 1, 1, 0, 0, 0, 1); @(negedge clk);
    chk("br_flush_if", 32'(flush_if), 32'd1);
    chk("br_issue", 32'(issue), 32'd1);
    adv();
    drv(1, 3, 4, 1, 1, 9, 1, 0, 0); @(negedge clk);
    chk("fl_issue", 32'(issue), 32'd0);
    chk("fl_bubble", 32'(bubble_ex), 32'd1);
    chk("fl_flush_if", 32'(flush_if), 32'd0);
    adv(); @(negedge clk);
    chk("fl_resume_issue", 32'(issue), 32'd1);
    adv(); drain();

    // lw x0; add x1,x0,x0 / lw x3; lui x3
    drv(1, 1, 0, 1, 0, 0, 1, 1, 0); adv();
    drv(1, 0, 0, 1, 1, 1, 1, 0, 0); @(negedge clk);
    chk("x0_stall", 32'(stall_if), 32'd0);
    chk("x0_fwd_a", 32'(fwd_a), 32'd0);
    chk("x0_fwd_b", 32'(fwd_b), 32'd0);
    adv(); drain();
    drv(1, 1, 0, 1, 0, 3, 1, 1, 0); adv();
    drv(1, 3, 3, 0, 0, 3, 1, 0, 0); @(negedge clk);
    chk("nouse_stall", 32'(stall_if), 32'd0);
    chk("nouse_fwd_a", 32'(fwd_a), 32'd0);
    adv(); drain();

    // EX and MEM both write x9
    drv(1, 1, 2, 1, 1, 9, 1, 0, 0); adv(); adv();
    drv(1, 9, 9, 1, 1, 10, 1, 0, 0); @(negedge clk);
    chk("prio_fwd_a", 32'(fwd_a), 32'd1);
    chk("prio_fwd_b", 32'(fwd_b), 32'd1);
    adv(); drain();

    // lw x7; beq x7,x0 redirecting
    drv(1, 1, 0, 1, 0, 7, 1, 1, 0); adv();
    drv(1, 7, 0, 1, 1, 0, 0, 0, 1); @(negedge clk);
    chk("lbr_stall_if", 32'(stall_if), 32'd1);
    chk("lbr_flush_held", 32'(flush_if), 32'd0);
    adv(); @(negedge clk);
    chk("lbr_fwd_a", 32'(fwd_a), 32'd2);
    chk("lbr_flush_if", 32'(flush_if), 32'd1);
    chk("lbr_issue", 32'(issue), 32'd1);
    chk("lbr_count", 32'(stall_count), 32'd2);
    adv(); drain();

    // async reset while stalled
    drv(1, 1, 0, 1, 0, 7, 1, 1, 0); adv();
    drv(1, 7, 7, 1, 1, 8, 1, 0, 0); @(negedge clk);
    chk("ar_pre_stall", 32'(stall_if), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_stall_drop", 32'(stall_if), 32'd0);
    chk("ar_count_clr", 32'(stall_count), 32'd0);
    adv();
    rst = 1'b0;
    @(negedge clk);
    chk("ar_post_stall", 32'(stall_if), 32'd0);
    chk("ar_post_issue", 32'(issue), 32'd1);
    chk("ar_post_fwd_a", 32'(fwd_a), 32'd0);
    adv(); drain();

    // five load-use stalls
    for (int i = 0; i < 5; i++) begin
      drv(1, 1, 0, 1, 0, 7, 1, 1, 0); adv();
      drv(1, 7, 7, 1, 1, 8, 1, 0, 0); adv(); adv();
    end
    drain();
    chk("sat_count2", 32'(stall_count2), 32'd3);
    chk("sat_count16", 32'(stall_count), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
